// File: rtl/msg_fifo_feeder.sv
// Message FIFO between the LFSR source and the DES unit.
// First-word fall-through with sticky overflow and drain tracking.
module msg_fifo_feeder #(
    parameter int N         = 64,
    parameter int DEPTH     = 8,
    parameter int AF_MARGIN = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic [N-1:0]               lfsr_in,
    input  logic                       lfsr_valid,
    input  logic                       lfsr_done,
    output logic                       lfsr_pause,
    output logic [N-1:0]               msg_out,
    output logic                       msg_valid,
    input  logic                       des_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic                       all_sent
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  wr_q, wr_d;
    logic [AW-1:0]  rd_q, rd_d;
    logic [LW-1:0]  level_q, level_d;
    logic           overflow_q, overflow_d;
    logic           all_sent_q;
    logic [N-1:0]   mem [DEPTH];

    logic full;
    logic push;
    logic pop;
    logic drop;

    always_comb begin
        full = (level_q == LW'(DEPTH));
        pop  = (level_q != '0) && des_ready;
        push = lfsr_valid && (!full || pop);
        drop = lfsr_valid && full && !pop;

        wr_d       = push ? wr_q + AW'(1) : wr_q;
        rd_d       = pop  ? rd_q + AW'(1) : rd_q;
        level_d    = level_q + LW'(push) - LW'(pop);
        overflow_d = overflow_q | drop;

        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (lfsr_done)
                    state_d = DRAIN;
                else if (lfsr_valid)
                    state_d = RUN;
            end
            RUN: begin
                if (lfsr_done)
                    state_d = DRAIN;
            end
            DRAIN: begin
                if (level_d == '0)
                    state_d = DONE;
            end
            DONE: state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_q       <= '0;
            rd_q       <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            all_sent_q <= 1'b0;
        end else if (flush) begin
            state_q    <= IDLE;
            wr_q       <= '0;
            rd_q       <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            all_sent_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            all_sent_q <= (state_d == DONE);
        end
    end

    // Storage is left unreset; only entries below level are ever observed.
    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_q] <= lfsr_in;
    end

    assign msg_out    = mem[rd_q];
    assign msg_valid  = (level_q != '0);
    assign level      = level_q;
    assign overflow   = overflow_q;
    assign all_sent   = all_sent_q;
    assign lfsr_pause = (level_q >= LW'(DEPTH - AF_MARGIN));

endmodule

// File: tb/tb_msg_fifo_feeder.sv
// Directed bench for msg_fifo_feeder (N=64, DEPTH=8, AF_MARGIN=2).
// Inputs change 1ns after the rising edge; outputs sampled there.
module tb_msg_fifo_feeder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [63:0] lfsr_in;
    logic        lfsr_valid;
    logic        lfsr_done;
    logic        lfsr_pause;
    logic [63:0] msg_out;
    logic        msg_valid;
    logic        des_ready;
    logic [3:0]  level;
    logic        overflow;
    logic        all_sent;

    int checks = 0;
    int errors = 0;

    msg_fifo_feeder #(
        .N(64),
        .DEPTH(8),
        .AF_MARGIN(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .flush(flush),
        .lfsr_in(lfsr_in),
        .lfsr_valid(lfsr_valid),
        .lfsr_done(lfsr_done),
        .lfsr_pause(lfsr_pause),
        .msg_out(msg_out),
        .msg_valid(msg_valid),
        .des_ready(des_ready),
        .level(level),
        .overflow(overflow),
        .all_sent(all_sent)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] lfsr_nx(input logic [63:0] v);
        return {v[62:0], v[63] ^ v[62] ^ v[60] ^ v[59]};
    endfunction

    task automatic do_flush();
        flush      = 1'b1;
        lfsr_valid = 1'b0;
        des_ready  = 1'b0;
        lfsr_done  = 1'b0;
        tick();
        flush = 1'b0;
    endtask

    logic [63:0] exp_q[$];
    logic [63:0] x;
    logic        p;
    int          mlev;

    initial begin
        rst_n      = 1'b0;
        flush      = 1'b0;
        lfsr_in    = '0;
        lfsr_valid = 1'b0;
        lfsr_done  = 1'b0;
        des_ready  = 1'b0;
        #2;
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_mvalid", 64'(msg_valid), 64'd0);
        chk("rst_pause", 64'(lfsr_pause), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_allsent", 64'(all_sent), 64'd0);
        #11;
        rst_n = 1'b1;
        tick();

        // streaming, no bypass when empty
        des_ready  = 1'b1;
        lfsr_valid = 1'b1;
        lfsr_in    = 64'h1;
        tick();
        chk("st_out1", msg_out, 64'h1);
        chk("st_lvl1", 64'(level), 64'd1);
        chk("st_state_run", 64'(dut.state_q), 64'd1);
        lfsr_in = 64'h2;
        tick();
        chk("st_out2", msg_out, 64'h2);
        chk("st_lvl2", 64'(level), 64'd1);
        lfsr_in = 64'h3;
        tick();
        chk("st_out3", msg_out, 64'h3);
        chk("st_lvl3", 64'(level), 64'd1);
        lfsr_valid = 1'b0;
        tick();
        chk("st_lvl_end", 64'(level), 64'd0);
        chk("st_mvalid_end", 64'(msg_valid), 64'd0);

        // backpressure with a registered-pause LFSR
        des_ready  = 1'b0;
        x          = 64'hACE1_0000_1234_5678;
        lfsr_valid = 1'b1;
        lfsr_in    = x;
        mlev       = 0;
        for (int c = 0; c < 12; c++) begin
            p = lfsr_pause;
            if (lfsr_valid) begin
                exp_q.push_back(lfsr_in);
                mlev++;
            end
            tick();
            if (lfsr_valid)
                x = lfsr_nx(x);
            lfsr_valid = !p;
            lfsr_in    = x;
            chk("bp_level", 64'(level), 64'(mlev));
            chk("bp_pause", 64'(lfsr_pause), 64'(mlev >= 6));
        end
        chk("bp_settle", 64'(level), 64'd7);
        chk("bp_ovf", 64'(overflow), 64'd0);
        lfsr_valid = 1'b0;
        des_ready  = 1'b1;
        for (int i = 0; i < 7; i++) begin
            chk("bp_drain", msg_out, exp_q[i]);
            tick();
        end
        chk("bp_empty", 64'(level), 64'd0);
        exp_q.delete();

        // overflow
        des_ready  = 1'b0;
        lfsr_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            lfsr_in = 64'h10 + 64'(i);
            tick();
            chk("ov_level", 64'(level), 64'((i < 8) ? i + 1 : 8));
            chk("ov_flag", 64'(overflow), 64'(i >= 8));
        end
        lfsr_valid = 1'b0;
        des_ready  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("ov_pop", msg_out, 64'h10 + 64'(i));
            tick();
        end
        chk("ov_empty", 64'(level), 64'd0);
        chk("ov_sticky", 64'(overflow), 64'd1);
        do_flush();
        chk("ov_flush", 64'(overflow), 64'd0);

        // full with simultaneous push/pop
        lfsr_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            lfsr_in = 64'h20 + 64'(i);
            tick();
        end
        chk("fp_full", 64'(level), 64'd8);
        lfsr_in   = 64'h28;
        des_ready = 1'b1;
        chk("fp_head", msg_out, 64'h20);
        tick();
        chk("fp_level", 64'(level), 64'd8);
        chk("fp_ovf", 64'(overflow), 64'd0);
        lfsr_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("fp_order", msg_out, 64'h21 + 64'(i));
            tick();
        end
        chk("fp_empty", 64'(level), 64'd0);

        // drain, done, flush
        do_flush();
        lfsr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            lfsr_in = 64'h30 + 64'(i);
            tick();
        end
        lfsr_valid = 1'b0;
        chk("dr_level", 64'(level), 64'd3);
        lfsr_done = 1'b1;
        des_ready = 1'b1;
        chk("dr_pop0", msg_out, 64'h30);
        tick();
        lfsr_done = 1'b0;
        chk("dr_state", 64'(dut.state_q), 64'd2);
        chk("dr_pop1", msg_out, 64'h31);
        chk("dr_allsent1", 64'(all_sent), 64'd0);
        tick();
        chk("dr_pop2", msg_out, 64'h32);
        chk("dr_allsent2", 64'(all_sent), 64'd0);
        tick();
        chk("dr_allsent3", 64'(all_sent), 64'd1);
        chk("dr_lvl0", 64'(level), 64'd0);
        tick();
        chk("dr_hold", 64'(all_sent), 64'd1);
        do_flush();
        chk("dr_fl_state", 64'(dut.state_q), 64'd0);
        chk("dr_fl_allsent", 64'(all_sent), 64'd0);
        chk("dr_fl_level", 64'(level), 64'd0);

        // reset mid-stream, no clock edge needed
        lfsr_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            lfsr_in = 64'h40 + 64'(i);
            tick();
        end
        lfsr_valid = 1'b0;
        chk("mr_pre", 64'(level), 64'd5);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mr_level", 64'(level), 64'd0);
        chk("mr_mvalid", 64'(msg_valid), 64'd0);
        chk("mr_pause", 64'(lfsr_pause), 64'd0);
        chk("mr_ovf", 64'(overflow), 64'd0);
        chk("mr_state", 64'(dut.state_q), 64'd0);
        #1;
        rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/msg_fifo_feeder.md
MSG_FIFO_FEEDER -- requirements
Module: msg_fifo_feeder

Interface
REQ-001 SHALL have parameter N, default 64: message word width; must match the upstream LFSR width.
REQ-002 SHALL have parameter DEPTH, default 8: FIFO entries; power of two, >= 4.
REQ-003 SHALL have parameter AF_MARGIN, default 2: almost-full slack; 2 <= AF_MARGIN < DEPTH.
REQ-004 SHALL have port clk  in  1: single clock; all state is updated on its rising edge.
REQ-005 SHALL have port rst_n  in  1: reset, asynchronous, active low.
REQ-006 SHALL have port flush  in  1: synchronous clear; tied to the LFSR reset_counter.
REQ-007 SHALL have port lfsr_in  in  N: message word from the LFSR.
REQ-008 SHALL have port lfsr_valid  in  1: lfsr_in valid this cycle.
REQ-009 SHALL have port lfsr_done  in  1: LFSR has wrapped to its seed.
REQ-010 SHALL have port lfsr_pause  out  1: pause request to the LFSR.
REQ-011 SHALL have port msg_out  out  N: head-of-FIFO word to the DES unit.
REQ-012 SHALL have port msg_valid  out  1: msg_out valid.
REQ-013 SHALL have port des_ready  in  1: DES unit accepts msg_out this cycle.
REQ-014 SHALL have port level  out  clog2(DEPTH)+1: current occupancy.
REQ-015 SHALL have port overflow  out  1: sticky; a word was dropped.
REQ-016 SHALL have port all_sent  out  1: every produced word has been handed to the DES unit.

Function
REQ-017 SHALL push lfsr_in when lfsr_valid=1 and FIFO not full, or when it is full and a pop occurs in the same cycle.
REQ-018 SHALL pop when msg_valid=1 and des_ready=1.
REQ-019 SHALL drive msg_valid=(level!=0) and msg_out=mem[rd_ptr] (first-word fall-through), so a pushed word is presented one cycle after its push edge.
REQ-020 SHALL NOT bypass: when empty, a same-cycle push and des_ready produce no pop.
REQ-021 SHALL deliver words in push order with no duplication.
REQ-022 SHALL wrap the read/write pointers modulo DEPTH.
REQ-023 SHALL update level as level+push-pop each cycle.
REQ-024 SHALL decode lfsr_pause combinationally from the level register only, as (level >= DEPTH-AF_MARGIN); no input-to-output path.
REQ-025 SHALL, on a push while full without a pop, drop the word, leave memory and level unchanged, and set overflow=1 until reset or flush.
REQ-026 SHALL implement FSM states IDLE, RUN, DRAIN and DONE, with these transitions:
- IDLE->RUN on the first lfsr_valid=1 (that word is pushed).
- RUN->DRAIN on lfsr_done=1.
- DRAIN->DONE when level==0 after the edge.
- DONE holds until flush.
REQ-027 SHALL go to DRAIN if lfsr_done=1 arrives in IDLE.
REQ-028 SHALL, in DRAIN/DONE, still accept lfsr_valid pushes (the LFSR's final valid cycle may coincide).
REQ-029 SHALL drive all_sent=1 only in DONE.
REQ-030 SHALL, on flush=1 in any state, go to IDLE at the next edge, zero the pointers, level and overflow, and discard any push or pop in that cycle; flush has priority over all other events.

Reset
REQ-031 SHALL, while rst_n=0, immediately force state=IDLE, pointers=0, level=0, overflow=0.
REQ-032 SHALL therefore show msg_valid=0, lfsr_pause=0, all_sent=0 during reset; msg_out is don't-care.
REQ-033 SHALL not reset memory contents.
REQ-034 SHALL treat reset asserted mid-operation identically; deassertion is synchronized externally.

Verification (N=64, DEPTH=8, AF_MARGIN=2)
REQ-035 SHALL cover reset mid-stream: rst_n=0 with level=5 -> level=0, msg_valid=0, lfsr_pause=0, overflow=0, state IDLE without waiting for a clock edge.
REQ-036 SHALL cover streaming: des_ready=1; push 0x1, 0x2, 0x3 on consecutive cycles -> msg_out=0x1, 0x2, 0x3 each one cycle after its push; level <= 1 throughout.
REQ-037 SHALL cover backpressure with the real LFSR model: des_ready=0 -> lfsr_pause=1 once level=6; one further push; level settles at 7; overflow=0; releasing des_ready drains 7 words in order.
REQ-038 SHALL cover overflow: des_ready=0; force lfsr_valid=1 for 10 cycles (words 0x10..0x19) -> level=8, overflow=1 after the 9th push; popped words are 0x10..0x17.
REQ-039 SHALL cover full with simultaneous push/pop: level=8, lfsr_valid=1, des_ready=1 -> level stays 8, overflow stays 0, order preserved.
REQ-040 SHALL cover drain/done/flush: level=3 and lfsr_done=1 with des_ready=1 -> 3 pops, then all_sent=1; flush=1 -> next cycle state IDLE, all_sent=0, level=0.
